// File: rtl/npc_arb_pkg.sv
// Shared encodings for the npc memory arbiter: FSM states, owner IDs and
// the fixed data values driven on fetches and on watchdog recovery.
package npc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam logic [7:0]  FETCH_WMASK  = 8'b0000_1111;

endpackage

// File: rtl/npc_arb_watchdog.sv
// Transaction watchdog: counts busy cycles, fires expire on the last allowed
// cycle unless the transaction completes then, and keeps a sticky error flag.
module npc_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic done,
  output logic expire,
  output logic err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic             err_q;

  // Completion on the expiry cycle wins over the timeout.
  assign expire      = enable && !done && (count == LAST);
  assign err_timeout = err_q | expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      err_q <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (enable && (count != LAST)) begin
        count <= count + CNT_W'(1);
      end
      if (expire) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight.
// Define ARB_RR_EN for round-robin arbitration instead of fixed LSU priority.
module npc_mem_arbiter
  import npc_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rsp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              err_timeout
);

  arb_state_e        state;
  arb_owner_e        owner;
  logic              grant_ifu;
  logic              grant_lsu;
  logic              expire;
  logic              done;
  logic              rsp_fire;
  logic [DATA_W-1:0] rsp_data;

`ifdef ARB_RR_EN
  arb_owner_e last_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= OWN_IFU;
    end else if (grant_lsu) begin
      last_grant <= OWN_LSU;
    end else if (grant_ifu) begin
      last_grant <= OWN_IFU;
    end
  end
`endif

  // Grants are only offered in IDLE and never while reset is asserted.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (reset && (state == IDLE)) begin
`ifdef ARB_RR_EN
      if (lsu_req_valid && ifu_req_valid) begin
        grant_lsu = (last_grant == OWN_IFU);
        grant_ifu = (last_grant == OWN_LSU);
      end else begin
        grant_lsu = lsu_req_valid;
        grant_ifu = ifu_req_valid;
      end
`else
      grant_lsu = lsu_req_valid;
      grant_ifu = ifu_req_valid && !lsu_req_valid;
`endif
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  npc_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == IDLE),
    .enable     (state != IDLE),
    .done       (done),
    .expire     (expire),
    .err_timeout(err_timeout)
  );

  assign done     = (state == RESP) && mem_rsp_valid;
  assign rsp_fire = done || expire;
  assign rsp_data = expire  ? DATA_W'(TIMEOUT_DATA) :
                    mem_wen ? '0 : mem_rsp_data;

  assign ifu_rsp_valid = rsp_fire && (owner == OWN_IFU);
  assign lsu_rsp_valid = rsp_fire && (owner == OWN_LSU);
  assign ifu_rsp_data  = ifu_rsp_valid ? rsp_data : '0;
  assign lsu_rsp_data  = lsu_rsp_valid ? rsp_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= OWN_IFU;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_lsu) begin
            owner         <= OWN_LSU;
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end else if (grant_ifu) begin
            owner         <= OWN_IFU;
            mem_addr      <= ifu_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= FETCH_WMASK;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (expire) begin
            mem_req_valid <= 1'b0;
            state         <= IDLE;
          end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (rsp_fire) begin
            state <= IDLE;
          end
        end
        default: begin
          mem_req_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Scoreboard bench for npc_mem_arbiter: a small memory model answers the
// memory port, expected responses are queued at accept and popped on output.
module tb_npc_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rsp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rsp_data;
  logic [7:0]    lsu_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rsp_data;
  logic [7:0]    mem_wmask;
  logic          err_timeout;

  npc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lsu;
    logic [31:0] data;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            n_acc_lsu = 0;
  int            ready_delay = 0;
  int            wait_cnt = 0;
  bit            hang = 0;
  bit            hs_mem = 0;
  bit            acc_ifu = 0;
  bit            acc_lsu = 0;
  logic [AW-1:0] m_addr = '0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a ^ 32'h8010_0073;
  endfunction

  // Sample at posedge+2: record handshakes, push expectations, pop responses.
  task automatic eval();
    exp_t e, got;
    #1;
    hs_mem  = mem_req_valid && mem_req_ready;
    if (hs_mem) m_addr = mem_addr;
    acc_ifu = ifu_req_valid && ifu_req_ready;
    acc_lsu = lsu_req_valid && lsu_req_ready;
    if (acc_ifu) sb.push_back(exp_t'{1'b0, hang ? 32'hDEAD_BEEF : mem_model(ifu_addr)});
    if (acc_lsu) begin
      n_acc_lsu++;
      sb.push_back(exp_t'{1'b1, hang ? 32'hDEAD_BEEF : (lsu_wen ? 32'h0 : mem_model(lsu_addr))});
    end
    if (ifu_rsp_valid || lsu_rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected ifu=%0b lsu=%0b expected no response", ifu_rsp_valid, lsu_rsp_valid);
      end else begin
        e   = sb.pop_front();
        got = exp_t'{lsu_rsp_valid, lsu_rsp_valid ? lsu_rsp_data : ifu_rsp_data};
        if (got !== e || (ifu_rsp_valid && lsu_rsp_valid)) begin
          errors++;
          $display("FAIL rsp_scoreboard got lsu=%0b data=%h both=%0b expected lsu=%0b data=%h",
                   got.lsu, got.data, ifu_rsp_valid && lsu_rsp_valid, e.lsu, e.data);
        end
      end
    end
  endtask

  // Advance one clock, drop accepted requests, drive the memory side.
  task automatic step();
    @(posedge clk);
    #1;
    if (acc_ifu) ifu_req_valid = 1'b0;
    if (acc_lsu) lsu_req_valid = 1'b0;
    acc_ifu = 0;
    acc_lsu = 0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (mem_req_valid) begin
      if (wait_cnt >= ready_delay) mem_req_ready = 1'b1;
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    if (hs_mem && !hang) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_model(m_addr);
    end
    hs_mem = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || ifu_req_valid || lsu_req_valid) && n < budget) begin
      eval();
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0 || ifu_req_valid || lsu_req_valid) begin
      errors++;
      $display("FAIL drain pending=%0d ifu_v=%0b lsu_v=%0b expected all served within %0d cycles",
               sb.size(), ifu_req_valid, lsu_req_valid, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b0;
    lsu_wdata = '0; lsu_wmask = 8'h0F;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, err_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 000000",
               {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, err_timeout});
    end
    checks++;
    if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
      errors++;
      $display("FAIL reset_mem addr=%h wen=%b wdata=%h wmask=%h expected all 0", mem_addr, mem_wen, mem_wdata, mem_wmask);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    reset = 1'b1;
  endtask

  task automatic test_ifu_fetch();
    ifu_addr = 32'h8000_0000; ifu_req_valid = 1'b1;
    eval();
    checks++;
    if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_accept ifu_ready=%b lsu_ready=%b expected 1 0", ifu_req_ready, lsu_req_ready);
    end
    step(); eval();
    checks++;
    if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_rsp_valid} !== {1'b1, 32'h8000_0000, 1'b0, 32'h0, 8'h0F, 1'b0}) begin
      errors++;
      $display("FAIL fetch_req valid=%b addr=%h wen=%b wdata=%h wmask=%h rsp=%b expected 1 80000000 0 0 0f 0",
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_rsp_valid);
    end
    step(); eval();
    checks++;
    if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'h0010_0073 || lsu_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_rsp valid=%b data=%h lsu_valid=%b expected 1 00100073 0", ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid);
    end
    step(); eval();
    checks++;
    if (ifu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_pulse rsp=%b req=%b expected 0 0", ifu_rsp_valid, mem_req_valid);
    end
    step();
  endtask

  task automatic test_contention();
    bit exp_ifu;
    ifu_addr = 32'h8000_0004; ifu_req_valid = 1'b1;
    lsu_addr = 32'h8000_1000; lsu_wen = 1'b1; lsu_wdata = 32'h1234_5678; lsu_wmask = 8'h0F; lsu_req_valid = 1'b1;
    eval();
    checks++;
    if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL contend1_grant lsu_ready=%b ifu_ready=%b expected 1 0", lsu_req_ready, ifu_req_ready);
    end
    step(); eval();
    checks++;
    if ({mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready} !== {32'h8000_1000, 1'b1, 32'h1234_5678, 8'h0F, 1'b0}) begin
      errors++;
      $display("FAIL contend1_mem addr=%h wen=%b wdata=%h wmask=%h ifu_ready=%b expected 80001000 1 12345678 0f 0",
               mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready);
    end
    step(); eval();
    checks++;
    if (lsu_rsp_valid !== 1'b1 || lsu_rsp_data !== 32'h0 || ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL store_ack valid=%b data=%h ifu_ready=%b expected 1 0 0", lsu_rsp_valid, lsu_rsp_data, ifu_req_ready);
    end
    step(); eval();
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ifu_after_ack ifu_ready=%b expected 1", ifu_req_ready);
    end
    step();
    drain(20);
    ifu_addr = 32'h8000_0008; ifu_req_valid = 1'b1;
    lsu_addr = 32'h8000_1004; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
    eval();
    checks++;
    if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL contend2_grant lsu_ready=%b ifu_ready=%b expected 1 0", lsu_req_ready, ifu_req_ready);
    end
    step(); eval(); step(); eval(); step();
    lsu_addr = 32'h8000_1008; lsu_req_valid = 1'b1;
    eval();
`ifdef ARB_RR_EN
    exp_ifu = 1'b1;
`else
    exp_ifu = 1'b0;
`endif
    checks++;
    if (ifu_req_ready !== exp_ifu || lsu_req_ready !== !exp_ifu) begin
      errors++;
      $display("FAIL contend3_grant ifu_ready=%b lsu_ready=%b expected %b %b", ifu_req_ready, lsu_req_ready, exp_ifu, !exp_ifu);
    end
    step();
    drain(40);
  endtask

  task automatic test_stall();
    int acc0 = n_acc_lsu;
    ready_delay = 3;
    lsu_addr = 32'h8000_2001; lsu_wen = 1'b1; lsu_wdata = 32'h0000_00A5; lsu_wmask = 8'h01; lsu_req_valid = 1'b1;
    eval();
    step();
    ifu_addr = 32'h8000_0010; ifu_req_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      eval();
      checks++;
      if ({mem_req_valid, mem_req_ready, mem_addr, mem_wdata, mem_wmask, ifu_req_ready, lsu_req_ready} !==
          {1'b1, 1'b0, 32'h8000_2001, 32'h0000_00A5, 8'h01, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_c%0d v=%b r=%b addr=%h wdata=%h wmask=%h ifu_rdy=%b lsu_rdy=%b expected 1 0 80002001 a5 01 0 0",
                 c, mem_req_valid, mem_req_ready, mem_addr, mem_wdata, mem_wmask, ifu_req_ready, lsu_req_ready);
      end
      step();
    end
    drain(30);
    checks++;
    if (n_acc_lsu - acc0 !== 1) begin
      errors++;
      $display("FAIL stall_accepts got %0d expected 1", n_acc_lsu - acc0);
    end
    ready_delay = 0;
  endtask

  task automatic test_expiry_boundary();
    ready_delay = 6;
    ifu_addr = 32'h8000_0020; ifu_req_valid = 1'b1;
    eval();
    step();
    for (int c = 1; c <= 7; c++) begin
      eval();
      step();
    end
    eval();
    checks++;
    if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== mem_model(32'h8000_0020) || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL expiry_completion valid=%b data=%h err=%b expected 1 %h 0",
               ifu_rsp_valid, ifu_rsp_data, err_timeout, mem_model(32'h8000_0020));
    end
    step();
    ready_delay = 0;
    eval();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL expiry_err_after got %b expected 0", err_timeout);
    end
    step();
  endtask

  task automatic test_timeout();
    hang = 1;
    ifu_addr = 32'h8000_0040; ifu_req_valid = 1'b1;
    eval();
    step();
    for (int c = 1; c <= 7; c++) begin
      eval();
      checks++;
      if (ifu_rsp_valid !== 1'b0 || err_timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early_c%0d rsp=%b err=%b expected 0 0", c, ifu_rsp_valid, err_timeout);
      end
      step();
    end
    eval();
    checks++;
    if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'hDEAD_BEEF || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire rsp=%b data=%h err=%b expected 1 deadbeef 1", ifu_rsp_valid, ifu_rsp_data, err_timeout);
    end
    step();
    hang = 0;
    eval();
    checks++;
    if (err_timeout !== 1'b1 || mem_req_valid !== 1'b0 || ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover err=%b req=%b ifu_ready=%b expected 1 0 0", err_timeout, mem_req_valid, ifu_req_ready);
    end
    step();
    lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; lsu_wmask = 8'h0F; lsu_req_valid = 1'b1;
    drain(20);
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b expected 1", err_timeout);
    end
  endtask

  task automatic test_async_reset();
    ifu_addr = 32'h8000_0080; ifu_req_valid = 1'b1;
    eval(); step(); eval(); step();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, err_timeout, ifu_req_ready, mem_addr, mem_wmask} !== '0) begin
      errors++;
      $display("FAIL async_reset rsp=%b/%b req=%b err=%b rdy=%b addr=%h wmask=%h expected all 0",
               ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, err_timeout, ifu_req_ready, mem_addr, mem_wmask);
    end
    sb.delete();
    hs_mem = 0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_req_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ifu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_hold rsp=%b req=%b expected 0 0", ifu_rsp_valid, mem_req_valid);
    end
    reset = 1'b1;
    ifu_addr = 32'h8000_0000; ifu_req_valid = 1'b1;
    eval();
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_accept got %b expected 1", ifu_req_ready);
    end
    step();
    drain(20);
  endtask

  task automatic test_spurious();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_1111;
    eval();
    checks++;
    if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_rsp ifu=%b lsu=%b req=%b expected 0 0 0", ifu_rsp_valid, lsu_rsp_valid, mem_req_valid);
    end
    step();
    ifu_addr = 32'h8000_0200; ifu_req_valid = 1'b1;
    eval();
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL spurious_idle ifu_ready=%b expected 1", ifu_req_ready);
    end
    step();
    drain(20);
  endtask

  initial begin
    test_reset();
    test_ifu_fetch();
    test_contention();
    test_stall();
    test_expiry_boundary();
    test_timeout();
    test_async_reset();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/npc_mem_arbiter.md
Name: npc_mem_arbiter

Overview:
Shares one physical memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the single-cycle npc core. It replaces direct per-stage memory calls with a valid/ready request channel and a response channel. Only one transaction is outstanding at a time. A watchdog counter flags and recovers from a hung memory.

Parameters:
ADDR_W, 32, address width of all request channels
DATA_W, 32, read/write data width
TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+RESP before the watchdog fires; must be ≥2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  fetch address
ifu_rsp_valid  out  1  one-cycle pulse, fetch data valid
ifu_rsp_data  out  DATA_W  fetched instruction
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  load/store address
lsu_wen  in  1  1 = store, 0 = load
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  8  byte write mask (8'b0000_0001 = sb, 8'b0000_1111 = sw)
lsu_rsp_valid  out  1  one-cycle pulse; load data valid or store acknowledged
lsu_rsp_data  out  DATA_W  load data (0 for stores)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  registered address
mem_wen  out  1  registered write enable
mem_wdata  out  DATA_W  registered write data
mem_wmask  out  8  registered mask; 8'b0000_1111 for fetches
mem_rsp_valid  in  1  memory response / write ack
mem_rsp_data  in  DATA_W  memory read data
err_timeout  out  1  sticky watchdog flag

Behaviour:
- FSM states: IDLE, REQ, RESP. The owner register records IFU or LSU.
- Reset (reset == 0, asynchronous):
  - state = IDLE, owner = IFU.
  - All mem_* outputs = 0; err_timeout = 0; watchdog count = 0.
  - rsp_valid outputs = 0; *_req_ready = 0.
- Reset asserted mid-transaction aborts it silently: no response pulse, no retry.
- IDLE:
  - Winner = LSU if lsu_req_valid, else IFU if ifu_req_valid. LSU has fixed priority.
  - The winner's req_ready is combinational: state == IDLE && winner. The loser's ready is 0.
  - On handshake: latch addr/wen/wdata/wmask into mem_* registers and latch owner; next state = REQ.
  - A fetch latches wen = 0, wdata = 0, wmask = 8'b0000_1111.
- REQ:
  - mem_req_valid = 1 with stable fields until mem_req_ready = 1.
  - On that edge: mem_req_valid deasserts and next state = RESP.
  - mem_req_valid and mem_req_ready are never combinationally dependent on each other.
- RESP:
  - owner_rsp_valid = mem_rsp_valid (combinational). owner_rsp_data = mem_rsp_data for loads/fetches, 0 for stores.
  - On mem_rsp_valid: next state = IDLE.
  - The non-owner's rsp_valid stays 0.
- mem_rsp_valid in IDLE or REQ is ignored.
- Minimum latency, request accept to response: 2 cycles. Back-to-back transactions: a new accept is possible on the cycle after the response.
- Watchdog:
  - The counter clears in IDLE and increments each cycle in REQ/RESP.
  - When count == TIMEOUT_CYCLES-1 with no completion that cycle:
    - err_timeout is set (sticky until reset) and mem_req_valid drops.
    - The owner receives rsp_valid = 1 with data 32'hDEAD_BEEF.
    - next state = IDLE.
  - Completion on the same cycle as expiry counts as completion; err is not set.
- Both requesters asserting valid in the same IDLE cycle: only the winner is accepted; the loser must hold its request.

Optional Feature:
Macro ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant register resets to IFU. On simultaneous requests the requester that was not last granted wins, so the first contention goes to LSU. A single requester always wins.
- Undefined: fixed LSU-over-IFU priority as above; no last_grant register.

Decomposition:
- Shared package npc_arb_pkg:
  - FSM state encoding (IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2)
  - owner encoding (OWN_IFU = 1'b0, OWN_LSU = 1'b1)
  - TIMEOUT_DATA = 32'hDEAD_BEEF
  - FETCH_WMASK = 8'b0000_1111
- One natural sub-module: npc_arb_watchdog, containing the counter, expiry compare and sticky err flag. It has clear/enable inputs and an expire output.

Test Plan:
- IFU only, ifu_addr = 0x80000000, memory ready immediately, rsp data 0x00100073 one cycle later:
  - ifu_req_ready pulses in cycle 0, mem_req_valid in cycle 1.
  - ifu_rsp_valid pulse with 0x00100073 in cycle 2; lsu_rsp_valid stays 0.
- Both valid in the same cycle, lsu_addr = 0x80001000 (sw, wdata 0x12345678, wmask 0x0F):
  - LSU is granted first and mem_wmask = 0x0F; IFU is granted in the IDLE after the LSU ack.
  - With ARB_RR_EN, a second contention grants IFU.
- mem_req_ready held 0 for 3 cycles: mem_addr, mem_wdata and mem_wmask are stable throughout, and there is exactly one accept.
- No mem_rsp_valid with TIMEOUT_CYCLES = 8: on the 8th cycle after accept, the owner receives rsp_valid with 0xDEADBEEF and err_timeout = 1, which stays high through later normal transactions.
- reset driven low asynchronously mid-RESP: outputs go to 0 immediately with no rsp pulse; after release, an IFU request completes normally.
- Spurious mem_rsp_valid in IDLE: no rsp_valid output, and the state stays IDLE.
